uart_frame_tx_controller: RTL

UART_FRAME_TX_CONTROLLER -- requirements
Module: uart_frame_tx_controller

---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/uart_frame_byte_sel.sv | 48 ++++
 rtl/uart_frame_tx_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame transmit controller.
// Holds the FSM state enum, the default sync bytes and the byte-index sizing.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_A_DEF = 8'h45;
  localparam logic [7:0] SYNC_B_DEF = 8'h53;

  localparam int HDR_BYTES = 4;
  // Largest sample: header, 8 data bytes, 4 pad bytes and a checksum byte.
  localparam int MAX_BYTES = HDR_BYTES + 8 + 4 + 1;
  localparam int IDX_W     = $clog2(MAX_BYTES);

endpackage

// File: rtl/uart_frame_byte_sel.sv
// Maps byte index, header flag and latched sample data to the byte to transmit.
// The checksum input exists only when UART_FRAME_CSUM_EN is defined.
module uart_frame_byte_sel
  import uart_frame_pkg::*;
#(
  parameter int         DATA_BYTES = 3,
  parameter int         PAD_BYTES  = 1,
  parameter logic [7:0] SYNC_A     = SYNC_A_DEF,
  parameter logic [7:0] SYNC_B     = SYNC_B_DEF
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic                    hdr,
  input  logic [8*DATA_BYTES-1:0] data,
`ifdef UART_FRAME_CSUM_EN
  input  logic [7:0]              csum,
`endif
  output logic [7:0]              byte_out
);

  logic [IDX_W-1:0] pos;

  // pos is the index within the body (payload, pad, checksum) of the sample.
  always_comb begin
    byte_out = 8'h00;
    pos      = idx;
    if (hdr) begin
      pos = idx - IDX_W'(HDR_BYTES);
      if (idx < IDX_W'(2))
        byte_out = SYNC_A;
      else if (idx < IDX_W'(HDR_BYTES))
        byte_out = SYNC_B;
    end
    if (!hdr || idx >= IDX_W'(HDR_BYTES)) begin
      if (pos < IDX_W'(DATA_BYTES)) begin
        for (int i = 0; i < DATA_BYTES; i++)
          if (pos == IDX_W'(i)) byte_out = data[i*8 +: 8];
      end else if (pos < IDX_W'(DATA_BYTES + PAD_BYTES)) begin
        byte_out = 8'h00;
      end
`ifdef UART_FRAME_CSUM_EN
      else begin
        byte_out = csum;
      end
`endif
    end
  end

endmodule

// File: rtl/uart_frame_tx_controller.sv
// Sequences one sample (optional sync header, payload, pad, checksum) into a UART byte transmitter.
// Define UART_FRAME_CSUM_EN to append a mod-256 checksum byte of payload and pad.
module uart_frame_tx_controller
  import uart_frame_pkg::*;
#(
  parameter int         DATA_BYTES = 3,
  parameter int         FRAME_NUM  = 1000,
  parameter int         PAD_BYTES  = 1,
  parameter logic [7:0] SYNC_A     = SYNC_A_DEF,
  parameter logic [7:0] SYNC_B     = SYNC_B_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send_en,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    tx_done,
  output logic                    tx_en,
  output logic [7:0]              tx_d,
  output logic                    busy,
  output logic                    send_done
);

`ifdef UART_FRAME_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int BODY_BYTES = DATA_BYTES + PAD_BYTES + CSUM_BYTES;
  localparam int CNT_W      = $clog2(FRAME_NUM);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic                    hdr;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [CNT_W-1:0]        sample_cnt;
  logic [7:0]              tx_d_q;
  logic [7:0]              sel_byte;
  logic                    last_byte;

  assign last_byte = (idx == (hdr ? IDX_W'(HDR_BYTES + BODY_BYTES - 1)
                                  : IDX_W'(BODY_BYTES - 1)));

`ifdef UART_FRAME_CSUM_EN
  logic [7:0] csum;

  // Pad bytes are zero, so summing the payload alone gives the same result.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++)
      csum = csum + data_q[i*8 +: 8];
  end
`endif

  uart_frame_byte_sel #(
    .DATA_BYTES (DATA_BYTES),
    .PAD_BYTES  (PAD_BYTES),
    .SYNC_A     (SYNC_A),
    .SYNC_B     (SYNC_B)
  ) u_byte_sel (
    .idx      (idx),
    .hdr      (hdr),
    .data     (data_q),
`ifdef UART_FRAME_CSUM_EN
    .csum     (csum),
`endif
    .byte_out (sel_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (send_en) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (tx_done) state_nxt = last_byte ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    tx_en     = (state == LOAD);
    busy      = (state == LOAD) || (state == WAIT);
    send_done = (state == DONE);
    // tx_d_q captures the byte in LOAD so it holds through WAIT and into IDLE.
    tx_d      = (state == LOAD) ? sel_byte : tx_d_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      hdr        <= 1'b0;
      data_q     <= '0;
      sample_cnt <= '0;
      tx_d_q     <= 8'h00;
    end else begin
      if (state == IDLE && send_en) begin
        data_q <= data;
        hdr    <= (sample_cnt == '0);
        idx    <= '0;
        if (sample_cnt == CNT_W'(FRAME_NUM - 1)) sample_cnt <= '0;
        else                                     sample_cnt <= sample_cnt + 1'b1;
      end
      if (state == LOAD)
        tx_d_q <= sel_byte;
      if (state == WAIT && tx_done && !last_byte)
        idx <= idx + 1'b1;
      if (state == DONE)
        idx <= '0;
    end
  end

endmodule
